mul_add_seq: RTL and testbench

MUL_ADD_SEQ -- requirements
Module: mul_add_seq

---
 rtl/mul_add_seq.sv | 95 +++++++++
 tb/tb_mul_add_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_add_seq.sv
// rtl/mul_add_seq.sv - sequential shift-add multiply-accumulate: product = multiplier*multiplicand + addend
// Rebuilds a dividend from a quotient, divisor and remainder, one multiplier bit per cycle.
module mul_add_seq #(
    parameter int len_q = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [len_q-1:0]      multiplier,
    input  logic [23:0]           multiplicand,
    input  logic [23:0]           addend,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [len_q+23:0]     product,
    output logic                  rem_ok
);

    localparam int PW = len_q + 24;
    localparam int CW = $clog2(len_q + 1);
    localparam logic [CW-1:0] LAST = CW'(len_q - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic [len_q-1:0] r_mplier;
    logic [23:0]      r_mcand;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_acc;
    logic             r_rem_ok;
    logic [PW-1:0]    w_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The working multiplier copy shifts right, so bit 0 is always the bit for the current counter.
    assign w_term = r_mplier[0] ? (PW'(r_mcand) << r_cnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mplier <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem_ok <= 1'b0;
        end else if (w_accept) begin
            r_mplier <= multiplier;
            r_mcand  <= multiplicand;
            r_cnt    <= '0;
            r_acc    <= PW'(addend);
            r_rem_ok <= (addend < multiplicand);
        end else if (r_state == BUSY) begin
            r_acc    <= r_acc + w_term;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = r_acc;
    assign rem_ok    = r_rem_ok;

endmodule

// File: tb/tb_mul_add_seq.sv
// tb/tb_mul_add_seq.sv - self-checking bench for mul_add_seq with a transaction-level model
module tb_mul_add_seq;
    localparam int LQ = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [LQ-1:0] multiplier;
    logic [23:0]   multiplicand;
    logic [23:0]   addend;
    logic          out_valid;
    logic          out_ready;
    logic [LQ+23:0] product;
    logic          rem_ok;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    mul_add_seq #(.len_q(LQ)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .multiplier(multiplier), .multiplicand(multiplicand), .addend(addend),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .rem_ok(rem_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Transaction model: 0 idle, 1 computing (m_left edges to go), 2 result held.
    int              m_phase = 0;
    int              m_left  = 0;
    logic [47:0]     m_prod  = '0;
    logic            m_rem   = 1'b0;
    longint unsigned m_tmp;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_tmp   = longint'(multiplier) * longint'(multiplicand) + longint'(addend);
                    m_prod  = m_tmp[47:0];
                    m_rem   = (addend < multiplicand);
                    m_left  = LQ;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_in_ready", 64'(in_ready), 64'(m_phase == 0));
            chk("model_out_valid", 64'(out_valid), 64'(m_phase == 2));
            if (m_phase == 2) begin
                chk("model_product", 64'(product), 64'(m_prod));
                chk("model_rem_ok", 64'(rem_ok), 64'(m_rem));
            end
        end
    end

    task automatic start(input logic [23:0] m, input logic [23:0] d, input logic [23:0] a);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) bound_fail("start_wait");
        in_valid     = 1'b1;
        multiplier   = m;
        multiplicand = d;
        addend       = a;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish(input int hold, input bit toggle, input bit chain,
                          output logic [47:0] prod, output logic rem, output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            if (toggle) begin
                in_valid     = 1'($urandom);
                multiplier   = 24'($urandom);
                multiplicand = 24'($urandom);
                addend       = 24'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) bound_fail("done_wait");
        prod = product;
        rem  = rem_ok;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_product", 64'(product), 64'(prod));
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        if (chain) begin
            in_valid     = 1'b1;
            multiplier   = 24'd9;
            multiplicand = 24'd9;
            addend       = 24'd9;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
    endtask

    function automatic void rdiv(input logic [23:0] n, input logic [23:0] d,
                                 output logic [23:0] q, output logic [23:0] r);
        logic [24:0] rm;
        rm = '0;
        q  = '0;
        for (int i = 23; i >= 0; i--) begin
            rm = {rm[23:0], n[i]};
            if (rm >= {1'b0, d}) begin
                rm   = rm - {1'b0, d};
                q[i] = 1'b1;
            end
        end
        r = rm[23:0];
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] p;
        logic        r;
        int          lat;
        logic [23:0] dvd, dvs, q, rm;
        int          w;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        multiplier = '0; multiplicand = '0; addend = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_product", 64'(product), 64'd0);
        chk("reset_rem_ok", 64'(rem_ok), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        start(24'd5, 24'd7, 24'd3);
        finish(0, 1'b0, 1'b0, p, r, lat);
        chk("basic_latency", 64'(lat), 64'd24);
        chk("basic_product", 64'(p), 64'd38);
        chk("basic_rem_ok", 64'(r), 64'd1);

        start(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        finish(0, 1'b0, 1'b0, p, r, lat);
        chk("max_product", 64'(p), 64'hFFFFFF000000);
        chk("max_rem_ok", 64'(r), 64'd0);

        start(24'd123, 24'd0, 24'd9);
        finish(0, 1'b0, 1'b0, p, r, lat);
        chk("zero_div_product", 64'(p), 64'd9);
        chk("zero_div_rem_ok", 64'(r), 64'd0);
        chk("zero_div_latency", 64'(lat), 64'd24);

        start(24'd100, 24'd200, 24'd50);
        finish(10, 1'b0, 1'b0, p, r, lat);
        chk("bp_product", 64'(p), 64'd20050);

        start(24'd1000, 24'd77, 24'd12);
        finish(0, 1'b1, 1'b0, p, r, lat);
        chk("ignore_product", 64'(p), 64'd77012);
        chk("ignore_rem_ok", 64'(r), 64'd1);

        start(24'hABCDEF, 24'h123, 24'd5);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_product", 64'(product), 64'd0);
        repeat (30) @(negedge clk);
        chk("midreset_no_result", 64'(out_valid), 64'd0);
        start(24'd2, 24'd3, 24'd1);
        finish(0, 1'b0, 1'b0, p, r, lat);
        chk("after_reset_product", 64'(p), 64'd7);

        start(24'd4, 24'd5, 24'd6);
        finish(2, 1'b0, 1'b1, p, r, lat);
        chk("handover_first", 64'(p), 64'd26);
        @(negedge clk);
        in_valid = 1'b0;
        chk("handover_accept_next", 64'(in_ready), 64'd0);
        finish(0, 1'b0, 1'b0, p, r, lat);
        chk("handover_second", 64'(p), 64'd90);
        chk("handover_latency", 64'(lat), 64'd24);

        for (int k = 0; k < 1000; k++) begin
            dvd = 24'($urandom);
            w   = $urandom_range(1, 24);
            dvs = 24'($urandom) & 24'((32'd1 << w) - 32'd1);
            if (dvs == 24'd0) dvs = 24'd1;
            rdiv(dvd, dvs, q, rm);
            start(q, dvs, rm);
            finish(0, 1'b0, 1'b0, p, r, lat);
            chk("roundtrip_dividend", 64'(p), 64'(dvd));
            chk("roundtrip_rem_ok", 64'(r), 64'd1);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
